// File: rtl/parallel_receiver.sv
// Receive end of the inter-FPGA parallel link: 4-phase valid/ready handshake
// with a synchronised valid, feeding a FIFO drained by a local read strobe.
module parallel_receiver #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_rx,
  input  logic                          rst_rx,
  input  logic [DATA_W-1:0]             parallel_data_in,
  input  logic                          parallel_valid_in,
  output logic                          parallel_ready_out,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             data_out,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   rx_word_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    WRITE          = 2'd1,
    WAIT_VALID_LOW = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync;
  logic                   valid_sync;
  logic [DATA_W-1:0]      hold_reg;
  logic [DATA_W-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count_nxt;
  logic                   wr, rd;

  assign valid_sync = sync[SYNC_STAGES-1];
  assign wr         = (state == WRITE);
  assign rd         = rd_en && !fifo_empty;

  always_ff @(posedge clk_rx) begin
    if (rst_rx) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], parallel_valid_in};
  end

  // Data is only trusted once valid has crossed the synchroniser.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (valid_sync && !fifo_full) state_nxt = WRITE;
      WRITE:
        state_nxt = WAIT_VALID_LOW;
      WAIT_VALID_LOW:
        if (!valid_sync) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_rx) begin
    if (rst_rx) begin
      state              <= IDLE;
      hold_reg           <= '0;
      parallel_ready_out <= 1'b0;
      rx_word_count      <= '0;
    end else begin
      state              <= state_nxt;
      parallel_ready_out <= (state_nxt == WAIT_VALID_LOW);
      if (state == IDLE && state_nxt == WRITE)
        hold_reg <= parallel_data_in;
      if (wr)
        rx_word_count <= rx_word_count + 16'd1;
    end
  end

  always_comb begin
    count_nxt = fifo_count;
    if (wr && !rd)      count_nxt = fifo_count + CW'(1);
    else if (!wr && rd) count_nxt = fifo_count - CW'(1);
  end

  always_ff @(posedge clk_rx) begin
    if (wr) mem[wr_ptr] <= hold_reg;
  end

  always_ff @(posedge clk_rx) begin
    if (rst_rx) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_out   <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      fifo_count <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == CW'(FIFO_DEPTH));
    end
  end

endmodule
